modexp_controller: RTL and testbench

- Parametrised successor to the single-step multiply/modulo sequencer.
- Drives the modular-exponentiation datapath using MSB-first square-and-multiply over an EXP_WIDTH-bit exponent.
- Supports multi-cycle multiplier and reducer latencies, a valid/ready start handshake, a held done handshake and a synchronous abort.
- Sits between the host/input-capture logic and the multiplier/modulo datapath.

---
 rtl/modexp_controller_if.sv | 31 +++
 rtl/modexp_controller.sv | 131 +++++++++++++
 tb/tb_modexp_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/modexp_controller_if.sv
// Handshake and datapath-control bundle between the host, the sequencer and the modexp datapath.
interface modexp_controller_if #(
    parameter int unsigned EXP_WIDTH = 16
);
    localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    logic                 start_valid;
    logic                 start_ready;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 abort;
    logic                 initialize;
    logic                 en_square;
    logic                 en_multiply;
    logic                 en_modulo;
    logic [IDX_W-1:0]     bit_index;
    logic                 busy;
    logic                 done;
    logic                 done_ready;

    modport master (
        output start_valid, exponent, abort, done_ready,
        input  start_ready, initialize, en_square, en_multiply, en_modulo,
               bit_index, busy, done
    );

    modport slave (
        input  start_valid, exponent, abort, done_ready,
        output start_ready, initialize, en_square, en_multiply, en_modulo,
               bit_index, busy, done
    );
endinterface

// File: rtl/modexp_controller.sv
// MSB-first square-and-multiply sequencer for the modular-exponentiation datapath.
// All outputs are flops loaded from the next-state decode, so they follow the state register exactly.
module modexp_controller #(
    parameter int unsigned EXP_WIDTH  = 16,
    parameter int unsigned MUL_CYCLES = 1,
    parameter int unsigned MOD_CYCLES = 1
) (
    input logic                clk,
    input logic                rst_n,
    modexp_controller_if.slave bus
);
    localparam int unsigned IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int unsigned CNT_MAX = (MUL_CYCLES > MOD_CYCLES) ? MUL_CYCLES : MOD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SQUARE  = 3'd2;
    localparam logic [2:0] S_SQ_MOD  = 3'd3;
    localparam logic [2:0] S_MULT    = 3'd4;
    localparam logic [2:0] S_MUL_MOD = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_q, bit_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic                 mul_last;
    logic                 mod_last;
    logic                 bit_end;
    logic                 in_burst;

    assign mul_last = (cnt_q == CNT_W'(MUL_CYCLES - 1));
    assign mod_last = (cnt_q == CNT_W'(MOD_CYCLES - 1));

    // Next-state, sub-cycle counter and bit pointer.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        exp_d    = exp_q;
        bit_end  = 1'b0;
        cnt_d    = '0;
        in_burst = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid && bus.start_ready) begin
                    state_d = S_INIT;
                    exp_d   = bus.exponent;
                    bit_d   = IDX_W'(EXP_WIDTH - 1);
                end
            end
            S_INIT: begin
                state_d = (exp_q == '0) ? S_DONE : S_SQUARE;
            end
            S_SQUARE: begin
                in_burst = 1'b1;
                if (mul_last) state_d = S_SQ_MOD;
            end
            S_SQ_MOD: begin
                in_burst = 1'b1;
                if (mod_last) begin
                    if (exp_q[bit_q]) state_d = S_MULT;
                    else              bit_end = 1'b1;
                end
            end
            S_MULT: begin
                in_burst = 1'b1;
                if (mul_last) state_d = S_MUL_MOD;
            end
            S_MUL_MOD: begin
                in_burst = 1'b1;
                if (mod_last) bit_end = 1'b1;
            end
            S_DONE: begin
                if (bus.done_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bit 0 finishes the exponent without moving the pointer.
        if (bit_end) begin
            if (bit_q == '0) begin
                state_d = S_DONE;
            end else begin
                bit_d   = bit_q - 1'b1;
                state_d = S_SQUARE;
            end
        end

        if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;

        if (in_burst && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            exp_q   <= exp_d;
        end
    end

    assign bus.bit_index = bit_q;

    // Moore output flops decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.start_ready <= 1'b0;
            bus.initialize  <= 1'b0;
            bus.en_square   <= 1'b0;
            bus.en_multiply <= 1'b0;
            bus.en_modulo   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.start_ready <= (state_d == S_IDLE);
            bus.initialize  <= (state_d == S_INIT);
            bus.en_square   <= (state_d == S_SQUARE);
            bus.en_multiply <= (state_d == S_MULT);
            bus.en_modulo   <= (state_d == S_SQ_MOD) || (state_d == S_MUL_MOD);
            bus.busy        <= (state_d != S_IDLE) && (state_d != S_DONE);
            bus.done        <= (state_d == S_DONE);
        end
    end
endmodule

// File: tb/tb_modexp_controller.sv
// Bench for modexp_controller: two configurations (1/1 and 3/2 cycle latencies), both EXP_WIDTH=4.
module tb_modexp_controller;
    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;

    modexp_controller_if #(.EXP_WIDTH(W)) ifa ();
    modexp_controller_if #(.EXP_WIDTH(W)) ifb ();

    modexp_controller #(.EXP_WIDTH(W), .MUL_CYCLES(1), .MOD_CYCLES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    modexp_controller #(.EXP_WIDTH(W), .MUL_CYCLES(3), .MOD_CYCLES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       init;
        logic       sq;
        logic       mu;
        logic       md;
        logic       busy;
        logic       done;
        logic       sready;
        logic [1:0] bidx;
    } obs_t;

    typedef struct {
        int         sel;
        logic [3:0] e;
        int         done_cyc;
        int         hold;
        logic       ab;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    obs_t tq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.init = ifa.initialize; o.sq = ifa.en_square; o.mu = ifa.en_multiply;
            o.md = ifa.en_modulo; o.busy = ifa.busy; o.done = ifa.done;
            o.sready = ifa.start_ready; o.bidx = ifa.bit_index;
        end else begin
            o.init = ifb.initialize; o.sq = ifb.en_square; o.mu = ifb.en_multiply;
            o.md = ifb.en_modulo; o.busy = ifb.busy; o.done = ifb.done;
            o.sready = ifb.start_ready; o.bidx = ifb.bit_index;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic sv, input logic [3:0] e,
                         input logic ab, input logic dr);
        if (sel == 0) begin
            ifa.start_valid = sv; ifa.exponent = e; ifa.abort = ab; ifa.done_ready = dr;
        end else begin
            ifb.start_valid = sv; ifb.exponent = e; ifb.abort = ab; ifb.done_ready = dr;
        end
    endtask

    function automatic obs_t mk(input logic i, input logic s, input logic x, input logic m,
                                input logic b, input logic d, input int bi);
        obs_t o;
        o.init = i; o.sq = s; o.mu = x; o.md = m; o.busy = b; o.done = d;
        o.sready = 1'b0; o.bidx = 2'(bi);
        return o;
    endfunction

    // Reference: per-cycle expected outputs, cycle 1 = first cycle after the handshake edge.
    task automatic build_trace(input logic [3:0] e, input int mc, input int dc);
        tq.delete();
        tq.push_back(mk(1, 0, 0, 0, 1, 0, W - 1));
        if (e != 0) begin
            for (int b = W - 1; b >= 0; b--) begin
                repeat (mc) tq.push_back(mk(0, 1, 0, 0, 1, 0, b));
                repeat (dc) tq.push_back(mk(0, 0, 0, 1, 1, 0, b));
                if (e[b]) begin
                    repeat (mc) tq.push_back(mk(0, 0, 1, 0, 1, 0, b));
                    repeat (dc) tq.push_back(mk(0, 0, 0, 1, 1, 0, b));
                end
            end
        end
        tq.push_back(mk(0, 0, 0, 0, 0, 1, (e == 0) ? W - 1 : 0));
    endtask

    task automatic start_op(input int sel, input logic [3:0] e, input logic ab);
        int n;
        n = 0;
        while (!get_obs(sel).sready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("start_ready_before_start", 32'(get_obs(sel).sready), 32'd1);
        drive(sel, 1'b1, e, ab, 1'b0);
        @(posedge clk);
        #1 drive(sel, 1'b0, 4'($urandom), 1'b0, 1'b0);
        build_trace(e, (sel == 0) ? 1 : 3, (sel == 0) ? 1 : 2);
    endtask

    task automatic run_op(input int sel, input logic [3:0] e, input int want_done,
                          input int hold, input logic ab);
        obs_t o;
        int   first_done;
        start_op(sel, e, ab);
        first_done = 0;
        for (int c = 1; c <= tq.size(); c++) begin
            @(negedge clk);
            o = get_obs(sel);
            check($sformatf("trace s%0d e%0h c%0d", sel, e, c), 32'(o), 32'(tq[c-1]));
            if (o.done && first_done == 0) first_done = c;
        end
        check($sformatf("done_cycle s%0d e%0h", sel, e), 32'(first_done), 32'(want_done));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            o = get_obs(sel);
            check("done_held", 32'({o.done, o.sready, o.busy}), 32'(3'b100));
        end
        drive(sel, 1'b0, 4'($urandom), 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(sel, 1'b0, 4'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        o = get_obs(sel);
        check("after_done_ready", 32'({o.done, o.sready, o.busy}), 32'(3'b010));
    endtask

    vec_t tbl[8];

    initial begin
        obs_t o;
        tbl[0] = '{sel: 0, e: 4'b1011, done_cyc: 16, hold: 1, ab: 1'b0};
        tbl[1] = '{sel: 0, e: 4'b0000, done_cyc: 2,  hold: 5, ab: 1'b0};
        tbl[2] = '{sel: 0, e: 4'b1111, done_cyc: 18, hold: 0, ab: 1'b0};
        tbl[3] = '{sel: 0, e: 4'b0001, done_cyc: 12, hold: 2, ab: 1'b1};
        tbl[4] = '{sel: 1, e: 4'b0001, done_cyc: 27, hold: 1, ab: 1'b0};
        tbl[5] = '{sel: 1, e: 4'b0000, done_cyc: 2,  hold: 5, ab: 1'b0};
        tbl[6] = '{sel: 1, e: 4'b1111, done_cyc: 42, hold: 0, ab: 1'b0};
        tbl[7] = '{sel: 1, e: 4'b1010, done_cyc: 32, hold: 3, ab: 1'b1};

        // Reset held with start_valid asserted.
        rst_n = 1'b0;
        drive(0, 1'b1, 4'b1011, 1'b0, 1'b0);
        drive(1, 1'b0, 4'b0000, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("reset_outs_a", 32'(get_obs(0)), 32'd0);
            check("reset_outs_b", 32'(get_obs(1)), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        o = get_obs(0);
        check("ready_after_release", 32'({o.sready, o.init, o.busy}), 32'(3'b100));
        run_op(0, 4'b1011, 16, 1, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].sel, tbl[i].e, tbl[i].done_cyc, tbl[i].hold, tbl[i].ab);

        // Abort during the second cycle of a multiply burst.
        start_op(1, 4'b1000, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("abort_pre c%0d", c), 32'(get_obs(1)), 32'(tq[c-1]));
        end
        drive(1, 1'b0, 4'b0000, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(1, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        o = get_obs(1);
        check("abort_to_idle", 32'({o.init, o.sq, o.mu, o.md, o.busy, o.done, o.sready}),
              32'(7'b0000001));
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_abort", 32'({get_obs(1).done, get_obs(1).busy}), 32'd0);
        end
        run_op(1, 4'b1000, 27, 1, 1'b0);

        // Asynchronous reset in the middle of a reduce step.
        start_op(0, 4'b1011, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("arst_pre c%0d", c), 32'(get_obs(0)), 32'(tq[c-1]));
        end
        #2 rst_n = 1'b0;
        #1 check("async_reset_a", 32'(get_obs(0)), 32'd0);
        check("async_reset_b", 32'(get_obs(1)), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        o = get_obs(0);
        check("idle_after_async", 32'({o.sready, o.busy, o.done}), 32'(3'b100));
        run_op(0, 4'b1011, 16, 0, 1'b0);

        // Random exponents on both configurations.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] e;
            int         sel;
            int         lat;
            sel = i % 2;
            e   = 4'($urandom);
            lat = (sel == 0) ? 2 : 5;
            run_op(sel, e, (e == 0) ? 2 : 2 + (W + $countones(e)) * lat,
                   $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
